// File: rtl/ws2812_serializer_if.sv
// Byte handshake between a colour pattern generator and the WS2812 serializer.
// The generator holds trigger with a stable color until data_request pulses.
interface ws2812_serializer_if;
    logic       trigger;
    logic [7:0] color;
    logic       data_request;

    modport master (
        output trigger,
        output color,
        input  data_request
    );

    modport slave (
        input  trigger,
        input  color,
        output data_request
    );
endinterface

// File: rtl/ws2812_serializer.sv
// WS2812 single-wire line driver: serialises colour bytes MSB-first into NRZ
// pulse timing and holds the line low for the latch interval between frames.
// Optional build macro: WS2812_OUTPUT_INVERT_EN inverts dout for an inverting
// level shifter (idle, reset and latch levels become 1).
module ws2812_serializer #(
    parameter int unsigned T0H_CYCLES   = 5,
    parameter int unsigned T1H_CYCLES   = 10,
    parameter int unsigned BIT_CYCLES   = 15,
    parameter int unsigned RESET_CYCLES = 720
) (
    input  logic                clk,
    input  logic                rst,
    ws2812_serializer_if.slave  up,
    output logic                dout,
    output logic                busy
);

    localparam int unsigned PhaseW = $clog2(BIT_CYCLES) + 1;
    localparam int unsigned LatchW = $clog2(RESET_CYCLES) + 1;

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BIT_CYCLES - 1);
    localparam logic [PhaseW-1:0] HighOne   = PhaseW'(T1H_CYCLES);
    localparam logic [PhaseW-1:0] HighZero  = PhaseW'(T0H_CYCLES);
    // Counting down to zero inclusive gives exactly RESET_CYCLES latch cycles.
    localparam logic [LatchW-1:0] LatchInit = LatchW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StLatch} state_e;

    state_e            state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sr_q, sr_d;
    logic [LatchW-1:0] latch_q, latch_d;
    logic              dreq_q, dreq_d;
    logic              wave;

    // Next-state, byte capture and the un-inverted pulse waveform.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        latch_d = latch_q;
        dreq_d  = 1'b0;
        wave    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (up.trigger) begin
                    sr_d    = up.color;
                    dreq_d  = 1'b1;
                    bit_d   = 3'd7;
                    phase_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                wave = (phase_q < (sr_q[7] ? HighOne : HighZero));
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                        sr_d  = {sr_q[6:0], 1'b0};
                    end else if (up.trigger) begin
                        // Gapless continuation into the next byte of the frame.
                        sr_d   = up.color;
                        dreq_d = 1'b1;
                        bit_d  = 3'd7;
                    end else begin
                        latch_d = LatchInit;
                        state_d = StLatch;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StLatch: begin
                if (latch_q == '0) begin
                    state_d = StIdle;
                end else begin
                    latch_d = latch_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            latch_q <= '0;
            dreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            latch_q <= latch_d;
            dreq_q  <= dreq_d;
        end
    end

    assign up.data_request = dreq_q;
    assign busy            = (state_q != StIdle);

`ifdef WS2812_OUTPUT_INVERT_EN
    assign dout = ~wave;
`else
    assign dout = wave;
`endif

endmodule
